// File: rtl/spi_pkg.sv
// Shared types and geometry for the SPI pixel unpacker.
package spi_pkg;
   localparam int DATA_WIDTH = 2;
   localparam int DATA_DEPTH = 16;
   localparam int SPI_WORD_W = DATA_WIDTH * DATA_DEPTH;
   localparam int IDX_W      = $clog2(DATA_DEPTH);

   typedef logic [SPI_WORD_W-1:0] spi_word_t;
   typedef logic [DATA_WIDTH-1:0] spi_elem_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } unpack_state_t;
endpackage

// File: rtl/spi_word_fifo.sv
// Small word FIFO; a write while full is accepted only when a read happens in the same cycle.
module spi_word_fifo
   import spi_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1),
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  wr_en,
   input  logic [SPI_WORD_W-1:0] wr_data,
   input  logic                  rd_en,
   output logic [SPI_WORD_W-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count
);

   spi_word_t        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_wr, do_rd;

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      do_rd    = rd_en && !empty;
      do_wr    = wr_en && (!full || do_rd);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
      count_d  = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + 1'b1;
      end else if (do_rd && !do_wr) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/spi_pixel_unpacker.sv
// Buffers SPI words and unpacks them into a valid/ready element stream.
// Define SPI_UNPACK_LSB_FIRST_EN to emit element 0 from the word LSBs instead of the MSBs.
module spi_pixel_unpacker
   import spi_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  word_valid,
   input  logic [SPI_WORD_W-1:0] word_in,
   input  logic                  pix_ready,
   output logic                  pix_valid,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  pix_last,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  overflow
);

   unpack_state_t    state_q, state_d;
   spi_word_t        word_q, word_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             overflow_q, overflow_d;

   logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
   spi_word_t        fifo_rd_data;
   logic             bypass, xfer, is_last;
   spi_elem_t        elems [DATA_DEPTH];

   spi_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .wr_en   (fifo_wr),
      .wr_data (word_in),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

`ifdef SPI_UNPACK_LSB_FIRST_EN
   for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_elem_lsb
      assign elems[gi] = word_q[gi*DATA_WIDTH +: DATA_WIDTH];
   end
`else
   for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_elem_msb
      assign elems[gi] = word_q[SPI_WORD_W-1-gi*DATA_WIDTH -: DATA_WIDTH];
   end
`endif

   assign pix_valid = (state_q == EMIT);
   assign pix_data  = elems[idx_q];
   assign pix_last  = is_last;
   assign overflow  = overflow_q;

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      idx_d    = idx_q;
      fifo_rd  = 1'b0;
      bypass   = 1'b0;
      is_last  = (idx_q == IDX_W'(DATA_DEPTH - 1));
      xfer     = pix_valid && pix_ready;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               word_d  = fifo_rd_data;
               idx_d   = '0;
               state_d = EMIT;
            end else if (word_valid) begin
               bypass  = 1'b1;
               word_d  = word_in;
               idx_d   = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (xfer) begin
               if (!is_last) begin
                  idx_d = idx_q + 1'b1;
               end else if (!fifo_empty) begin
                  // Back-to-back words: reload without a bubble.
                  fifo_rd = 1'b1;
                  word_d  = fifo_rd_data;
                  idx_d   = '0;
               end else begin
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      fifo_wr    = word_valid && !bypass;
      overflow_d = overflow_q || (fifo_wr && fifo_full && !fifo_rd);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q    <= IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: doc/spi_pixel_unpacker.md
Name: spi_pixel_unpacker

Overview:
- Sits directly downstream of the SPI input deserializer.
- Accepts each completed SPI word (DATA_DEPTH elements of DATA_WIDTH bits) on its one-cycle valid pulse and buffers it in a small word FIFO.
- Unpacks each word into a stream of DATA_WIDTH-bit elements on a valid/ready handshake, for the frame/pixel logic.
- Absorbs bursts of SPI words while the consumer stalls; reports dropped words.

Parameters:
- DATA_WIDTH, 2, bits per element.
- DATA_DEPTH, 16, elements per word.
- FIFO_DEPTH, 4, buffered words. Power of two, ≥2.

Ports:
- clk  input  1  system clock.
- nrst  input  1  synchronous active-low reset.
- word_valid  input  1  one-cycle pulse; word_in is valid this cycle.
- word_in  input  DATA_WIDTH*DATA_DEPTH  packed word; element 0 = MSBs (first bits shifted in).
- pix_ready  input  1  consumer accepts pix_data this cycle.
- pix_valid  output  1  pix_data holds a valid element.
- pix_data  output  DATA_WIDTH  current element.
- pix_last  output  1  current element is the final element (index DATA_DEPTH-1) of its word.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words held in FIFO; excludes the word being emitted.
- overflow  output  1  sticky: a word was dropped.

Behaviour:
- Reset is synchronous: on clk rising with nrst=0, FIFO pointers, count, element index, pix_valid, pix_data, pix_last and overflow all go to 0. Reset mid-word discards the word and all FIFO contents.
- Emit register: holds the active word plus element index idx (0..DATA_DEPTH-1).
  - FSM states: IDLE (no active word; pix_valid=0) and EMIT (pix_valid=1).
  - pix_data = active word bits [W-1-idx*DATA_WIDTH -: DATA_WIDTH].
  - pix_last = (idx == DATA_DEPTH-1).
- Transfer: occurs when pix_valid && pix_ready.
  - Non-last element: idx increments.
  - Last element: if FIFO is non-empty, pop it into the emit register with idx=0 and stay in EMIT (no bubble). If FIFO is empty, go to IDLE.
- IDLE with FIFO non-empty: pop next cycle, go to EMIT.
- Bypass path: word_valid while IDLE and FIFO empty loads the emit register directly. pix_valid=1 on the following cycle (latency 1).
- Otherwise word_valid writes word_in into the FIFO.
- Full boundary:
  - FIFO full, word_valid, and a pop in the same cycle: the write is accepted and count is unchanged.
  - FIFO full, word_valid, no pop: word dropped, overflow set to 1. overflow clears only on reset.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- pix_data, pix_last and pix_valid are stable while pix_valid=1 and pix_ready=0.
- word_valid high on consecutive cycles: each cycle is an independent word.

Optional Feature:
- SPI_UNPACK_LSB_FIRST_EN defined: element 0 = word_in[DATA_WIDTH-1:0], i.e. LSB-first unpack order.
- Undefined (default): MSB-first unpack order as specified above.
- All other behaviour is identical in both cases.

Decomposition:
- Package spi_pkg holds:
  - localparams DATA_WIDTH, DATA_DEPTH, SPI_WORD_W = DATA_WIDTH*DATA_DEPTH;
  - typedef spi_word_t (logic [SPI_WORD_W-1:0]);
  - typedef spi_elem_t (logic [DATA_WIDTH-1:0]);
  - enum unpack_state_t {IDLE, EMIT}.
- One sub-module, spi_word_fifo:
  - ports wr_en, wr_data, rd_en, rd_data, full, empty, count;
  - synchronous active-low reset;
  - simultaneous read and write when full is allowed.
- Unpack FSM and emit register live in the top module.

Test Plan:
- Reset, then a single word 0xE4E4_E4E4 with pix_ready=1 → pix_valid rises 1 cycle after word_valid. pix_data sequence is 3,2,1,0 repeated ×4. pix_last=1 only on the 16th element. Then IDLE.
- Two word_valid pulses 1 cycle apart (0xFFFF_FFFF, 0x0000_0000), pix_ready=1 → 16 elements of 3 immediately followed by 16 elements of 0. No idle cycle between words. fifo_count peaks at 1.
- pix_ready=0 while 5 words arrive (FIFO_DEPTH=4) → first word in emit register, fifo_count=4, overflow=0. A 6th word → overflow=1, fifo_count stays 4. Release ready → exactly 5 words emitted in order.
- FIFO full and the last element of the active word transfers in the same cycle as word_valid → word accepted, fifo_count stays 4, overflow stays 0.
- Random pix_ready toggling → pix_data/pix_last held while stalled. Total transfers = 16 × words accepted.
- nrst=0 for one cycle mid-word (idx=7, fifo_count=2) → next cycle pix_valid=0, fifo_count=0, overflow=0. A subsequent word is emitted cleanly from element 0.
